// File: rtl/alu_nibble_serial_if.sv
// alu_nibble_serial_if: start/done handshake, operands, function select and result bundle for alu_nibble_serial
interface alu_nibble_serial_if #(parameter int WIDTH = 16);
  logic start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0] S;
  logic M;
  logic Cn_;
  logic busy;
  logic done;
  logic [WIDTH-1:0] F;
  logic Cnplus;
  logic Eq;
  logic zero;
  logic ovf;
  modport master (output start, A, B, S, M, Cn_, input busy, done, F, Cnplus, Eq, zero, ovf);
  modport slave (input start, A, B, S, M, Cn_, output busy, done, F, Cnplus, Eq, zero, ovf);
endinterface

// File: rtl/alu_nibble_serial.sv
// alu_nibble_serial: 74181 function set on WIDTH bits, NPC nibbles per clock, LSB first; ALU_SERIAL_OVF_EN enables signed overflow
module alu_nibble_serial #(
  parameter int WIDTH = 16,
  parameter int NPC = 1
) (
  input logic clk,
  input logic rst,
  alu_nibble_serial_if.slave bus
);
  localparam int G = 4 * NPC;
  localparam int N = WIDTH / G;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [CW-1:0] cyc;
  logic [WIDTH-1:0] a_r, b_r, acc, fw, f_q;
  logic [3:0] s_r;
  logic m_r, carry, busy_q, done_q, cnp_q, eq_q, zero_q;
  logic [G-1:0] ag, bg, x, y, fg;
  logic [G:0] c;
  logic last;
  always_comb begin
    ag = a_r[cyc*G +: G];
    bg = b_r[cyc*G +: G];
    x = ag | (bg & {G{s_r[0]}}) | (~bg & {G{s_r[1]}});
    y = (ag & ~bg & {G{s_r[2]}}) | (ag & bg & {G{s_r[3]}});
    c = '0;
    c[0] = carry;
    fg = '0;
    for (int k = 0; k < G; k++) begin
      fg[k] = m_r ? ~(x[k] ^ y[k]) : x[k] ^ y[k] ^ c[k];
      c[k+1] = m_r ? 1'b0 : (x[k] & y[k]) | (c[k] & (x[k] ^ y[k]));
    end
    fw = acc;
    fw[cyc*G +: G] = fg;
    last = cyc == CW'(N - 1);
  end
`ifdef ALU_SERIAL_OVF_EN
  logic ovf_q;
  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cyc <= '0;
      acc <= '0;
      carry <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      f_q <= '0;
      cnp_q <= 1'b1;
      eq_q <= 1'b0;
      zero_q <= 1'b1;
`ifdef ALU_SERIAL_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          a_r <= bus.A;
          b_r <= bus.B;
          s_r <= bus.S;
          m_r <= bus.M;
          carry <= ~bus.Cn_;
          cyc <= '0;
          busy_q <= 1'b1;
          state <= RUN;
        end
      end else begin
        acc <= fw;
        carry <= c[G];
        cyc <= last ? '0 : cyc + 1'b1;
        if (last) begin
          state <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          f_q <= fw;
          cnp_q <= m_r | ~c[G];
          eq_q <= &fw;
          zero_q <= ~|fw;
`ifdef ALU_SERIAL_OVF_EN
          ovf_q <= ~m_r & (c[G-1] ^ c[G]);
`endif
        end
      end
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.F = f_q;
  assign bus.Cnplus = cnp_q;
  assign bus.Eq = eq_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_alu_nibble_serial.sv
// tb_alu_nibble_serial: table vectors, random ops vs integer model, and handshake corner cases on NPC=1 and NPC=2 instances
module tb_alu_nibble_serial;
`ifdef ALU_SERIAL_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  typedef struct {
    logic [15:0] f;
    logic cnp, eq, zero, ovf;
  } exp_t;
  typedef struct {
    logic [15:0] a, b;
    logic [3:0] s;
    logic m, cn;
    logic [15:0] f;
    logic cnp, eq, zero, ovf;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  alu_nibble_serial_if #(.WIDTH(16)) i1 ();
  alu_nibble_serial_if #(.WIDTH(16)) i2 ();
  alu_nibble_serial #(.WIDTH(16), .NPC(1)) dut1 (.clk(clk), .rst(rst), .bus(i1));
  alu_nibble_serial #(.WIDTH(16), .NPC(2)) dut2 (.clk(clk), .rst(rst), .bus(i2));
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] a, b, input logic [3:0] s, input logic m, cn);
    logic [15:0] x, y;
    logic [16:0] sum;
    exp_t e;
    x = a | (b & {16{s[0]}}) | (~b & {16{s[1]}});
    y = (a & ~b & {16{s[2]}}) | (a & b & {16{s[3]}});
    sum = {1'b0, x} + {1'b0, y} + {16'b0, ~cn};
    e.f = m ? ~(x ^ y) : sum[15:0];
    e.cnp = m ? 1'b1 : ~sum[16];
    e.ovf = OVF & ~m & (x[15] == y[15]) & (sum[15] != x[15]);
    e.eq = &e.f;
    e.zero = e.f == 16'h0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, b, input logic [3:0] s, input logic m, cn);
    i1.A = a; i1.B = b; i1.S = s; i1.M = m; i1.Cn_ = cn;
    i2.A = a; i2.B = b; i2.S = s; i2.M = m; i2.Cn_ = cn;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " busy"}, {31'b0, i1.busy}, 0);
    chk({tag, " done"}, {31'b0, i1.done}, 0);
    chk({tag, " F"}, {16'b0, i1.F}, 0);
    chk({tag, " Cnplus"}, {31'b0, i1.Cnplus}, 1);
    chk({tag, " Eq"}, {31'b0, i1.Eq}, 0);
    chk({tag, " zero"}, {31'b0, i1.zero}, 1);
    chk({tag, " ovf"}, {31'b0, i1.ovf}, 0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, b, input logic [3:0] s,
                        input logic m, cn, input exp_t e);
    int lat1, lat2;
    exp_t g1, g2;
    lat1 = 0; lat2 = 0;
    g1 = '{16'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    g2 = g1;
    drive(a, b, s, m, cn);
    i1.start = 1'b1; i2.start = 1'b1;
    @(posedge clk); #1;
    i1.start = 1'b0; i2.start = 1'b0;
    drive(~a, ~b, ~s, ~m, ~cn);
    for (int k = 1; k <= 10 && (lat1 == 0 || lat2 == 0); k++) begin
      @(posedge clk); #1;
      if (lat1 == 0 && i1.done) begin lat1 = k; g1 = '{i1.F, i1.Cnplus, i1.Eq, i1.zero, i1.ovf}; end
      if (lat2 == 0 && i2.done) begin lat2 = k; g2 = '{i2.F, i2.Cnplus, i2.Eq, i2.zero, i2.ovf}; end
    end
    chk({tag, " n1 latency"}, lat1, 4);
    chk({tag, " n1 F"}, {16'b0, g1.f}, {16'b0, e.f});
    chk({tag, " n1 Cnplus"}, {31'b0, g1.cnp}, {31'b0, e.cnp});
    chk({tag, " n1 Eq"}, {31'b0, g1.eq}, {31'b0, e.eq});
    chk({tag, " n1 zero"}, {31'b0, g1.zero}, {31'b0, e.zero});
    chk({tag, " n1 ovf"}, {31'b0, g1.ovf}, {31'b0, e.ovf});
    chk({tag, " n2 latency"}, lat2, 2);
    chk({tag, " n2 F"}, {16'b0, g2.f}, {16'b0, e.f});
    chk({tag, " n2 Cnplus"}, {31'b0, g2.cnp}, {31'b0, e.cnp});
    chk({tag, " n2 Eq"}, {31'b0, g2.eq}, {31'b0, e.eq});
    chk({tag, " n2 zero"}, {31'b0, g2.zero}, {31'b0, e.zero});
    chk({tag, " n2 ovf"}, {31'b0, g2.ovf}, {31'b0, e.ovf});
  endtask

  initial begin
    vec_t vecs[11];
    exp_t e;
    int dones, lat;
    logic [15:0] ra, rb;
    logic [3:0] rs;
    logic rm, rc;
    vecs[0]  = '{16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 16'h2233, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{16'h5A5A, 16'h5A5B, 4'b0110, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b1, 16'h0FF0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{16'hA5A5, 16'hFFFF, 4'b1011, 1'b1, 1'b0, 16'hA5A5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'h1234, 16'h5555, 4'b0000, 1'b1, 1'b1, 16'hEDCB, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'h0000, 16'h0000, 4'b1111, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{16'h1000, 16'h3C3C, 4'b0000, 1'b0, 1'b0, 16'h1001, 1'b1, 1'b0, 1'b0, 1'b0};
    i1.start = 1'b0; i2.start = 1'b0;
    drive(16'h0, 16'h0, 4'h0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset("reset");
    chk("reset n2 F", {16'b0, i2.F}, 0);
    chk("reset n2 Cnplus", {31'b0, i2.Cnplus}, 1);
    for (int v = 0; v < 11; v++) begin
      e = '{vecs[v].f, vecs[v].cnp, vecs[v].eq, vecs[v].zero, vecs[v].ovf & OVF};
      run_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].s, vecs[v].m, vecs[v].cn, e);
    end
    for (int r = 0; r < 40; r++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 4'($urandom);
      rm = 1'($urandom); rc = 1'($urandom);
      run_op($sformatf("rand%0d", r), ra, rb, rs, rm, rc, model(ra, rb, rs, rm, rc));
    end
    // start while busy must be ignored, not queued
    drive(16'h0001, 16'h0002, 4'b1001, 1'b0, 1'b1);
    i1.start = 1'b1;
    @(posedge clk); #1;
    drive(16'h0100, 16'h0100, 4'b1001, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 i1.start = 1'b0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (i1.done) begin
        dones++;
        chk("busy-start F", {16'b0, i1.F}, 32'h0003);
      end
    end
    chk("busy-start dones", dones, 1);
    // reset mid-run aborts without done
    drive(16'h4321, 16'h1111, 4'b1001, 1'b0, 1'b1);
    i1.start = 1'b1;
    @(posedge clk); #1 i1.start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_reset("abort");
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (i1.done) dones++;
    end
    chk("abort dones", dones, 0);
    // start in the done cycle is accepted at the next edge
    drive(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b1);
    i1.start = 1'b1;
    @(posedge clk); #1 i1.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (i1.done) lat = k;
    end
    chk("b2b first latency", lat, 4);
    chk("b2b first F", {16'b0, i1.F}, 32'h0002);
    drive(16'h0003, 16'h0004, 4'b1001, 1'b0, 1'b1);
    i1.start = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk); #1;
      i1.start = 1'b0;
      if (i1.done) lat = k;
    end
    chk("b2b second spacing", lat, 5);
    chk("b2b second F", {16'b0, i1.F}, 32'h0007);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
